// File: rtl/exdes_wqe_pkg.sv
// Shared types and constants for the SQ doorbell scheduler.
// FSM encoding, default doorbell addressing and PI/CI width.
package exdes_wqe_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    HNDSHK = 1'b1
  } state_t;

  localparam logic [31:0] DB_ADDR_BASE_DEF = 32'h5004_0338;
  localparam logic [31:0] DB_STRIDE_DEF    = 32'h0000_0100;
  localparam int          IDX_W            = 16;

  function automatic int qp_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exdes_sq_db_sched_if.sv
// Bundle of the WQE-post, CI-feedback and ERNIC doorbell signals.
// slave = the scheduler side, master = the environment driving posts and accepting doorbells.
interface exdes_sq_db_sched_if #(
  parameter int QPW = 2
);
  // Handshakes: a transfer happens on any clock edge where valid and ready/rdy are both high;
  // the doorbell side holds valid, addr and data stable until that edge.
  logic           post_wqe_valid;
  logic [QPW-1:0] post_wqe_qp;
  logic           post_wqe_ready;

  logic           cq_ci_valid;
  logic [QPW-1:0] cq_ci_qp;
  logic [15:0]    cq_ci_value;

  logic [15:0]    o_qp_sq_pidb_hndshk;
  logic [31:0]    o_qp_sq_pidb_wr_addr_hndshk;
  logic           o_qp_sq_pidb_wr_valid_hndshk;
  logic           i_qp_sq_pidb_wr_rdy;

  modport slave (
    input  post_wqe_valid, post_wqe_qp, cq_ci_valid, cq_ci_qp, cq_ci_value,
    input  i_qp_sq_pidb_wr_rdy,
    output post_wqe_ready, o_qp_sq_pidb_hndshk, o_qp_sq_pidb_wr_addr_hndshk,
    output o_qp_sq_pidb_wr_valid_hndshk
  );

  modport master (
    output post_wqe_valid, post_wqe_qp, cq_ci_valid, cq_ci_qp, cq_ci_value,
    output i_qp_sq_pidb_wr_rdy,
    input  post_wqe_ready, o_qp_sq_pidb_hndshk, o_qp_sq_pidb_wr_addr_hndshk,
    input  o_qp_sq_pidb_wr_valid_hndshk
  );

endinterface

// File: rtl/exdes_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
// The pointer register is owned by the parent.
module exdes_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/exdes_sq_db_sched.sv
// Multi-QP send-queue doorbell scheduler: per-QP PI/CI/pending, RR doorbell issue.
// Define EXDES_SQ_DB_COALESCE_EN to ring one doorbell for min(pending, space) WQEs.
module exdes_sq_db_sched
  import exdes_wqe_pkg::*;
#(
  parameter int          NUM_QP       = 4,
  parameter int          SQ_DEPTH     = 16,
  parameter int          PEND_W       = 8,
  parameter logic [31:0] DB_ADDR_BASE = DB_ADDR_BASE_DEF,
  parameter logic [31:0] DB_STRIDE    = DB_STRIDE_DEF,
  localparam int         QPW          = qp_w(NUM_QP)
) (
  input  logic                 core_clk,
  input  logic                 core_aresetn,
  input  logic                 conf_of_reg_done,
  input  logic                 RDMA_SND_TST_DONE,
  exdes_sq_db_sched_if.slave   bus,
  output logic [31:0]          o_db_count,
  output logic                 o_idle,
  output state_t               o_state
);

  localparam logic [IDX_W-1:0] MASK = IDX_W'(SQ_DEPTH - 1);

  state_t state, state_nxt;

  logic [IDX_W-1:0]  pi    [NUM_QP];
  logic [IDX_W-1:0]  ci    [NUM_QP];
  logic [PEND_W-1:0] pend  [NUM_QP];
  logic [PEND_W-1:0] pend_nxt [NUM_QP];
  logic [IDX_W-1:0]  space [NUM_QP];
  logic [NUM_QP-1:0] elig;

  logic [QPW-1:0]    rr_ptr, qp_sel, gnt_idx;
  logic [NUM_QP-1:0] gnt_oh;
  logic              gnt_any;

  logic [IDX_W-1:0]  gnt_pi, gnt_space, hndshk_q;
  logic [PEND_W-1:0] gnt_pend, k_grant, k_q;
  logic [31:0]       addr_q, db_count;

  logic enable, grant, done, post_fire, post_full, all_empty;

  assign enable = conf_of_reg_done & RDMA_SND_TST_DONE;

  // Out-of-range QP matches no entry and therefore reads as full.
  always_comb begin
    post_full = 1'b1;
    for (int q = 0; q < NUM_QP; q++) begin
      if (bus.post_wqe_qp == QPW'(q)) post_full = (pend[q] == '1);
    end
  end

  assign bus.post_wqe_ready = enable & ~post_full;
  assign post_fire          = bus.post_wqe_valid & bus.post_wqe_ready;

  always_comb begin
    all_empty = 1'b1;
    for (int q = 0; q < NUM_QP; q++) begin
      space[q] = MASK - ((pi[q] - ci[q]) & MASK);
      elig[q]  = enable && (pend[q] != '0) && (space[q] != '0);
      if (pend[q] != '0) all_empty = 1'b0;
    end
  end

  exdes_rr_arbiter #(
    .N  (NUM_QP),
    .IW (QPW)
  ) u_arb (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (gnt_oh),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    gnt_pi    = '0;
    gnt_space = '0;
    gnt_pend  = '0;
    for (int q = 0; q < NUM_QP; q++) begin
      if (gnt_oh[q]) begin
        gnt_pi    = pi[q];
        gnt_space = space[q];
        gnt_pend  = pend[q];
      end
    end
  end

  // Doorbell step size: one WQE per doorbell unless coalescing is built in.
  always_comb begin
`ifdef EXDES_SQ_DB_COALESCE_EN
    if (32'(gnt_pend) < 32'(gnt_space)) k_grant = gnt_pend;
    else                                k_grant = PEND_W'(gnt_space);
`else
    k_grant = (gnt_pend != '0 || gnt_space != '0) ? PEND_W'(1) : PEND_W'(1);
`endif
  end

  assign grant = (state == IDLE) & gnt_any;
  assign done  = (state == HNDSHK) & bus.i_qp_sq_pidb_wr_rdy;

  // FSM: state register
  always_ff @(posedge core_clk) begin
    if (!core_aresetn) state <= IDLE;
    else               state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = HNDSHK;
      HNDSHK:  if (bus.i_qp_sq_pidb_wr_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.o_qp_sq_pidb_wr_valid_hndshk = (state == HNDSHK);
    bus.o_qp_sq_pidb_wr_addr_hndshk  = addr_q;
    bus.o_qp_sq_pidb_hndshk          = hndshk_q;
    o_idle                           = (state == IDLE) & all_empty;
    o_state                          = state;
    o_db_count                       = db_count;
  end

  // A post and a doorbell completion on the same QP net out in one cycle.
  always_comb begin
    for (int q = 0; q < NUM_QP; q++) begin
      pend_nxt[q] = pend[q];
      if (post_fire && bus.post_wqe_qp == QPW'(q)) pend_nxt[q] = pend_nxt[q] + PEND_W'(1);
      if (done && qp_sel == QPW'(q))               pend_nxt[q] = pend_nxt[q] - k_q;
    end
  end

  always_ff @(posedge core_clk) begin
    if (!core_aresetn) begin
      for (int q = 0; q < NUM_QP; q++) begin
        pi[q]   <= '0;
        ci[q]   <= '0;
        pend[q] <= '0;
      end
      rr_ptr   <= '0;
      qp_sel   <= '0;
      k_q      <= '0;
      hndshk_q <= '0;
      addr_q   <= '0;
      db_count <= '0;
    end else begin
      if (grant) begin
        qp_sel   <= gnt_idx;
        k_q      <= k_grant;
        addr_q   <= DB_ADDR_BASE + 32'(gnt_idx) * DB_STRIDE;
        hndshk_q <= (gnt_pi + IDX_W'(k_grant)) & MASK;
      end
      if (done) begin
        rr_ptr   <= (int'(qp_sel) == NUM_QP - 1) ? '0 : qp_sel + QPW'(1);
        db_count <= db_count + 32'd1;
      end
      for (int q = 0; q < NUM_QP; q++) begin
        pend[q] <= pend_nxt[q];
        if (done && qp_sel == QPW'(q)) pi[q] <= hndshk_q;
        if (bus.cq_ci_valid && bus.cq_ci_qp == QPW'(q)) ci[q] <= bus.cq_ci_value & MASK;
      end
    end
  end

endmodule

// File: tb/tb_exdes_sq_db_sched.sv
// Bench for exdes_sq_db_sched: directed scenarios plus random traffic against a queue-level model.
// Build with EXDES_SQ_DB_COALESCE_EN to exercise the coalescing variant of the model.
module tb_exdes_sq_db_sched;
  import exdes_wqe_pkg::*;

  localparam int NQ   = 4;
  localparam int D    = 4;
  localparam int PW   = 3;
  localparam int PMAX = (1 << PW) - 1;
`ifdef EXDES_SQ_DB_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        conf = 1'b0;
  logic        tst = 1'b0;
  logic [31:0] db_count;
  logic        idle;
  state_t      dut_state;

  exdes_sq_db_sched_if #(.QPW(2)) bus ();

  exdes_sq_db_sched #(
    .NUM_QP   (NQ),
    .SQ_DEPTH (D),
    .PEND_W   (PW)
  ) dut (
    .core_clk          (clk),
    .core_aresetn      (rst_n),
    .conf_of_reg_done  (conf),
    .RDMA_SND_TST_DONE (tst),
    .bus               (bus.slave),
    .o_db_count        (db_count),
    .o_idle            (idle),
    .o_state           (dut_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: SQ occupancy bookkeeping at the doorbell level
  int m_pi[NQ], m_ci[NQ], m_pend[NQ];
  int m_ptr, m_busy, m_sel, m_k, m_hnd, m_cnt;
  logic [31:0] m_addr;
  int g, gk, qi, pq;
  bit en, post_ok;

  function automatic int m_space(input int q);
    return (D - 1) - ((((m_pi[q] - m_ci[q]) % D) + D) % D);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int q = 0; q < NQ; q++) begin
        m_pi[q] = 0; m_ci[q] = 0; m_pend[q] = 0;
      end
      m_ptr = 0; m_busy = 0; m_sel = 0; m_k = 0; m_hnd = 0; m_cnt = 0; m_addr = '0;
    end else begin
      en = conf && tst;
      g  = -1;
      gk = 1;
      if (!m_busy && en) begin
        for (int i = 0; i < NQ; i++) begin
          qi = (m_ptr + i) % NQ;
          if (g < 0 && m_pend[qi] > 0 && m_space(qi) > 0) g = qi;
        end
        if (g >= 0 && COAL) gk = (m_pend[g] < m_space(g)) ? m_pend[g] : m_space(g);
      end
      pq = int'(bus.post_wqe_qp);
      post_ok = bus.post_wqe_valid && pq < NQ && en && m_pend[pq] < PMAX;
      if (m_busy && bus.i_qp_sq_pidb_wr_rdy) begin
        m_pi[m_sel]   = m_hnd;
        m_pend[m_sel] = m_pend[m_sel] - m_k;
        m_ptr         = (m_sel + 1) % NQ;
        m_cnt         = m_cnt + 1;
        m_busy        = 0;
      end
      if (post_ok) m_pend[pq] = m_pend[pq] + 1;
      if (bus.cq_ci_valid) m_ci[int'(bus.cq_ci_qp)] = int'(bus.cq_ci_value) % D;
      if (g >= 0) begin
        m_busy = 1;
        m_sel  = g;
        m_k    = gk;
        m_hnd  = (m_pi[g] + gk) % D;
        m_addr = 32'h5004_0338 + 32'(g) * 32'h100;
      end
    end
  end

  // Compare process: every cycle once reset has been applied
  int  log_qp[$];
  int  log_hnd[$];
  logic [31:0] log_addr[$];
  logic [31:0] exp_q[$];
  bit  any_pend;

  always @(negedge clk) begin
    if (chk_on) begin
      any_pend = 1'b0;
      for (int q = 0; q < NQ; q++) if (m_pend[q] != 0) any_pend = 1'b1;
      check("valid", 32'(bus.o_qp_sq_pidb_wr_valid_hndshk), 32'(m_busy));
      check("state", 32'(dut_state), 32'(m_busy));
      if (m_busy != 0) begin
        check("addr", bus.o_qp_sq_pidb_wr_addr_hndshk, m_addr);
        check("hndshk", 32'(bus.o_qp_sq_pidb_hndshk), 32'(m_hnd));
      end
      check("db_count", db_count, 32'(m_cnt));
      check("idle", 32'(idle), 32'(m_busy == 0 && !any_pend));
      check("post_ready", 32'(bus.post_wqe_ready),
            32'(conf && tst && m_pend[int'(bus.post_wqe_qp)] < PMAX));
      if (bus.o_qp_sq_pidb_wr_valid_hndshk && bus.i_qp_sq_pidb_wr_rdy) begin
        log_qp.push_back(int'((bus.o_qp_sq_pidb_wr_addr_hndshk - 32'h5004_0338) >> 8));
        log_hnd.push_back(int'(bus.o_qp_sq_pidb_hndshk));
        log_addr.push_back(bus.o_qp_sq_pidb_wr_addr_hndshk);
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic post(input int q);
    bus.post_wqe_valid = 1'b1;
    bus.post_wqe_qp    = 2'(q);
    tick(1);
    bus.post_wqe_valid = 1'b0;
  endtask

  task automatic set_ci(input int q, input int v);
    bus.cq_ci_valid = 1'b1;
    bus.cq_ci_qp    = 2'(q);
    bus.cq_ci_value = 16'(v);
    tick(1);
    bus.cq_ci_valid = 1'b0;
  endtask

  task automatic clear_log();
    log_qp.delete();
    log_hnd.delete();
    log_addr.delete();
    exp_q.delete();
  endtask

  task automatic check_log_hnd(input string name);
    check({name, "_len"}, 32'(log_hnd.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_hnd.size(); i++)
      check(name, 32'(log_hnd[i]), exp_q[i]);
  endtask

  initial begin
    bus.post_wqe_valid      = 1'b0;
    bus.post_wqe_qp         = '0;
    bus.cq_ci_valid         = 1'b0;
    bus.cq_ci_qp            = '0;
    bus.cq_ci_value         = '0;
    bus.i_qp_sq_pidb_wr_rdy = 1'b0;
    tick(2);
    chk_on = 1'b1;
    rst_n  = 1'b1;
    check("rst_valid", 32'(bus.o_qp_sq_pidb_wr_valid_hndshk), 32'd0);
    check("rst_count", db_count, 32'd0);
    check("rst_idle", 32'(idle), 32'd1);

    // Gating: disabled posts are refused
    bus.i_qp_sq_pidb_wr_rdy = 1'b1;
    for (int i = 0; i < 3; i++) post(0);
    tick(3);
    check("gate_count", db_count, 32'd0);
    check("gate_ready", 32'(bus.post_wqe_ready), 32'd0);

    conf = 1'b1;
    tst  = 1'b1;
    tick(1);
    clear_log();
    for (int i = 0; i < 3; i++) post(0);
    tick(8);
    if (!COAL) begin
      exp_q = '{32'd1, 32'd2, 32'd3};
      check_log_hnd("basic_hnd");
      for (int i = 0; i < log_addr.size(); i++) check("basic_addr", log_addr[i], 32'h5004_0338);
      check("basic_count", db_count, 32'd3);
    end
    check("basic_idle", 32'(idle), 32'd1);
    set_ci(0, 3);

    // Fairness: queue work on all QPs behind a stalled doorbell
    clear_log();
    bus.i_qp_sq_pidb_wr_rdy = 1'b0;
    for (int r = 0; r < 2; r++) for (int q = 0; q < NQ; q++) post(q);
    bus.i_qp_sq_pidb_wr_rdy = 1'b1;
    tick(20);
    if (!COAL) begin
      check("rr_len", 32'(log_qp.size()), 32'd8);
      for (int i = 0; i < 8 && i < log_qp.size(); i++) begin
        check("rr_qp", 32'(log_qp[i]), 32'(i % NQ));
        check("rr_addr", log_addr[i], 32'h5004_0338 + 32'(i % NQ) * 32'h100);
      end
    end
    check("rr_idle", 32'(idle), 32'd1);

    // Stability under backpressure, enable drop mid-handshake
    set_ci(2, 2);
    bus.i_qp_sq_pidb_wr_rdy = 1'b0;
    post(2);
    tick(10);
    post(2);
    conf = 1'b0;
    tick(3);
    bus.i_qp_sq_pidb_wr_rdy = 1'b1;
    tick(6);
    check("endrop_valid", 32'(bus.o_qp_sq_pidb_wr_valid_hndshk), 32'd0);
    check("endrop_idle", 32'(idle), 32'd0);
    conf = 1'b1;
    tick(6);

    // Reset in the middle of a handshake
    bus.i_qp_sq_pidb_wr_rdy = 1'b0;
    post(3);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("mrst_valid", 32'(bus.o_qp_sq_pidb_wr_valid_hndshk), 32'd0);
    check("mrst_count", db_count, 32'd0);
    clear_log();
    bus.i_qp_sq_pidb_wr_rdy = 1'b1;
    post(3);
    tick(3);
    exp_q = '{32'd1};
    check_log_hnd("mrst_hnd");
    if (log_addr.size() > 0) check("mrst_addr", log_addr[0], 32'h5004_0638);

    // SQ full: QP1 stalls at 3 outstanding, then wraps after CI moves
    clear_log();
    for (int i = 0; i < 5; i++) post(1);
    tick(15);
    if (!COAL) begin
      exp_q = '{32'd1, 32'd2, 32'd3};
      check_log_hnd("full_hnd");
    end
    check("full_idle", 32'(idle), 32'd0);
    set_ci(1, 2);
    tick(10);
    if (!COAL) begin
      exp_q = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
      check_log_hnd("wrap_hnd");
      check("wrap_count", db_count, 32'd6);
    end

    // Pending saturation
    bus.i_qp_sq_pidb_wr_rdy = 1'b0;
    for (int i = 0; i < 10; i++) post(0);
    bus.i_qp_sq_pidb_wr_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_ci(0, 16'(m_pi[0]));
      tick(3);
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      bus.post_wqe_valid      = ($urandom_range(0, 1) == 1);
      bus.post_wqe_qp         = 2'($urandom_range(0, NQ - 1));
      bus.cq_ci_valid         = ($urandom_range(0, 9) == 0);
      bus.cq_ci_qp            = 2'($urandom_range(0, NQ - 1));
      bus.cq_ci_value         = 16'($urandom_range(0, 65535));
      bus.i_qp_sq_pidb_wr_rdy = ($urandom_range(0, 9) < 7);
      conf                    = ($urandom_range(0, 19) != 0);
      rst_n                   = ($urandom_range(0, 499) != 0);
      tick(1);
    end
    bus.post_wqe_valid = 1'b0;
    bus.cq_ci_valid    = 1'b0;
    rst_n              = 1'b1;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
